// File: rtl/i2c_bus_mon.sv
// i2c_bus_mon: synchronise, de-glitch and decode raw I2C SCL/SDA pad inputs
// Ports:
//   clk, rst (async, active-low)     clock and reset
//   scl_in, sda_in                   raw asynchronous pad inputs
//   tmo_limit [TMO_W-1:0]            stuck-low limit in clk cycles, 0 disables
//   clr                              clears stuck_scl/stuck_sda
//   scl_f, sda_f                     filtered line levels
//   scl_rise, scl_fall               one-cycle SCL edge pulses
//   start_det, stop_det              one-cycle START/STOP pulses
//   busy                             bus held between START and STOP
//   stuck_scl, stuck_sda             sticky stuck-low flags
module i2c_bus_mon #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int TMO_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_in,
    input  logic             sda_in,
    input  logic [TMO_W-1:0] tmo_limit,
    input  logic             clr,
    output logic             scl_f,
    output logic             sda_f,
    output logic             scl_rise,
    output logic             scl_fall,
    output logic             start_det,
    output logic             stop_det,
    output logic             busy,
    output logic             stuck_scl,
    output logic             stuck_sda
);
    localparam int CW = FILT_LEN > 1 ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CMAX = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic [CW-1:0]          scl_cnt, sda_cnt;
    logic [TMO_W-1:0]       scl_low, sda_low;
    logic                   scl_d, sda_d;
    logic                   s_scl, s_sda;

    assign s_scl = scl_sync[SYNC_STAGES-1];
    assign s_sda = sda_sync[SYNC_STAGES-1];

    // Edge and condition decode uses only registered levels, so every pulse is glitch-free
    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_cnt   <= '0;
            sda_cnt   <= '0;
            scl_f     <= 1'b1;
            sda_f     <= 1'b1;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            scl_low   <= '0;
            sda_low   <= '0;
            busy      <= 1'b0;
            stuck_scl <= 1'b0;
            stuck_sda <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            // A level change is accepted only after FILT_LEN consecutive differing samples
            scl_cnt   <= (s_scl == scl_f || scl_cnt == CMAX) ? '0 : scl_cnt + 1'b1;
            sda_cnt   <= (s_sda == sda_f || sda_cnt == CMAX) ? '0 : sda_cnt + 1'b1;
            scl_f     <= (s_scl != scl_f && scl_cnt == CMAX) ? s_scl : scl_f;
            sda_f     <= (s_sda != sda_f && sda_cnt == CMAX) ? s_sda : sda_f;
            scl_d     <= scl_f;
            sda_d     <= sda_f;
            scl_low   <= scl_f ? '0 : (&scl_low ? scl_low : scl_low + 1'b1);
            sda_low   <= sda_f ? '0 : (&sda_low ? sda_low : sda_low + 1'b1);
            busy      <= start_det ? 1'b1 : stop_det ? 1'b0 : busy;
            // clr wins for one cycle; a still-true condition re-arms the flag next cycle
            stuck_scl <= clr ? 1'b0 : (tmo_limit != '0 && scl_low >= tmo_limit) ? 1'b1 : stuck_scl;
            stuck_sda <= clr ? 1'b0 : (tmo_limit != '0 && sda_low >= tmo_limit) ? 1'b1 : stuck_sda;
        end
    end
endmodule

// File: tb/tb_i2c_bus_mon.sv
// tb_i2c_bus_mon: self-checking bench for i2c_bus_mon
module tb_i2c_bus_mon;
    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int TW = 16;
    localparam int unsigned LOW_MAX = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst, scl_in, sda_in, clr;
    logic [TW-1:0] tmo_limit;
    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, busy, stuck_scl, stuck_sda;

    int checks = 0;
    int errors = 0;
    int n_rise, n_fall, n_start, n_stop;

    bit m_f[2], m_d[2], m_stk[2], m_busy;
    int unsigned m_run[2], m_low[2];
    bit q_scl[$], q_sda[$];

    typedef struct {
        bit scl, sda, clr;
        int n;
        bit e_scl, e_sda, e_busy, e_sk_scl, e_sk_sda;
    } vec_t;
    vec_t tbl[16];

    i2c_bus_mon #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT), .TMO_W(TW)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .tmo_limit(tmo_limit), .clr(clr),
        .scl_f(scl_f), .sda_f(sda_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
        .start_det(start_det), .stop_det(stop_det), .busy(busy),
        .stuck_scl(stuck_scl), .stuck_sda(stuck_sda)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        q_scl = {};
        q_sda = {};
        repeat (SYNC) begin
            q_scl.push_back(1'b1);
            q_sda.push_back(1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            m_f[i] = 1'b1;
            m_d[i] = 1'b1;
            m_stk[i] = 1'b0;
            m_run[i] = 0;
            m_low[i] = 0;
        end
        m_busy = 1'b0;
    endtask

    // Behavioural model: inputs appear SYNC cycles late, a level is accepted after FILT
    // consecutive differing samples, low time is a run length, events come from old/new levels
    task automatic step();
        bit s, st, sp;
        st = m_f[0] & m_d[0] & m_d[1] & ~m_f[1];
        sp = m_f[0] & m_d[0] & ~m_d[1] & m_f[1];
        for (int i = 0; i < 2; i++) begin
            s = (i == 0) ? q_scl[$] : q_sda[$];
            m_stk[i] = clr ? 1'b0 : (tmo_limit != 0 && m_low[i] >= tmo_limit) ? 1'b1 : m_stk[i];
            m_low[i] = m_f[i] ? 0 : (m_low[i] == LOW_MAX ? LOW_MAX : m_low[i] + 1);
            m_d[i] = m_f[i];
            m_run[i] = (s != m_f[i]) ? m_run[i] + 1 : 0;
            if (m_run[i] == FILT) begin
                m_f[i] = s;
                m_run[i] = 0;
            end
        end
        m_busy = st ? 1'b1 : sp ? 1'b0 : m_busy;
        q_scl.push_front(scl_in);
        void'(q_scl.pop_back());
        q_sda.push_front(sda_in);
        void'(q_sda.pop_back());
    endtask

    task automatic cyc();
        logic [8:0] act, expv;
        @(posedge clk);
        if (rst) step();
        @(negedge clk);
        act = {scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, busy, stuck_scl, stuck_sda};
        expv = {m_f[0], m_f[1], m_f[0] & ~m_d[0], ~m_f[0] & m_d[0],
                m_f[0] & m_d[0] & m_d[1] & ~m_f[1], m_f[0] & m_d[0] & ~m_d[1] & m_f[1],
                m_busy, m_stk[0], m_stk[1]};
        chk("model", int'(act), int'(expv));
        n_rise += int'(scl_rise);
        n_fall += int'(scl_fall);
        n_start += int'(start_det);
        n_stop += int'(stop_det);
    endtask

    task automatic clr_counts();
        n_rise = 0;
        n_fall = 0;
        n_start = 0;
        n_stop = 0;
    endtask

    initial begin
        int lat, seen, hold;
        //           scl sda clr  n  f_scl f_sda busy sk_scl sk_sda
        tbl[0]  = '{1, 1, 0, 10, 1, 1, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 8,  1, 0, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 8,  0, 0, 1, 0, 0};
        tbl[3]  = '{0, 1, 0, 8,  0, 1, 1, 0, 0};
        tbl[4]  = '{1, 1, 0, 8,  1, 1, 1, 0, 0};
        tbl[5]  = '{1, 0, 0, 8,  1, 0, 1, 0, 0};
        tbl[6]  = '{1, 1, 0, 8,  1, 1, 0, 0, 0};
        tbl[7]  = '{0, 1, 0, 30, 0, 1, 0, 1, 0};
        tbl[8]  = '{1, 1, 0, 8,  1, 1, 0, 1, 0};
        tbl[9]  = '{1, 1, 1, 1,  1, 1, 0, 0, 0};
        tbl[10] = '{1, 1, 0, 4,  1, 1, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 40, 0, 0, 0, 1, 1};
        tbl[12] = '{1, 1, 1, 1,  0, 0, 0, 0, 0};
        tbl[13] = '{1, 1, 0, 1,  0, 0, 0, 1, 1};
        tbl[14] = '{1, 1, 0, 10, 1, 1, 0, 1, 1};
        tbl[15] = '{1, 1, 1, 1,  1, 1, 0, 0, 0};

        rst = 1'b1;
        scl_in = 1'b0;
        sda_in = 1'b0;
        clr = 1'b0;
        tmo_limit = '0;
        clr_counts();
        #1 rst = 1'b0;
        model_reset();
        repeat (3) cyc();
        chk("rst_scl_f", int'(scl_f), 1);
        chk("rst_sda_f", int'(sda_f), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pulses", n_rise + n_fall + n_start + n_stop, 0);

        rst = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (!scl_f && lat == 0) lat = i;
        end
        chk("rst_release_latency", lat, SYNC + FILT);
        scl_in = 1'b1;
        sda_in = 1'b1;
        repeat (12) cyc();

        clr_counts();
        scl_in = 1'b0;
        repeat (3) cyc();
        scl_in = 1'b1;
        repeat (12) cyc();
        chk("glitch3_fall", n_fall, 0);
        chk("glitch3_scl_f", int'(scl_f), 1);
        clr_counts();
        scl_in = 1'b0;
        repeat (4) cyc();
        scl_in = 1'b1;
        repeat (12) cyc();
        chk("pulse4_fall", n_fall, 1);
        chk("pulse4_rise", n_rise, 1);

        clr_counts();
        sda_in = 1'b0;
        repeat (10) cyc();
        chk("start_cnt", n_start, 1);
        chk("start_busy", int'(busy), 1);
        scl_in = 1'b0;
        repeat (10) cyc();
        sda_in = 1'b1;
        repeat (10) cyc();
        scl_in = 1'b1;
        repeat (10) cyc();
        sda_in = 1'b0;
        repeat (10) cyc();
        chk("rstart_cnt", n_start, 2);
        chk("rstart_busy", int'(busy), 1);
        chk("rstart_no_stop", n_stop, 0);
        scl_in = 1'b0;
        repeat (10) cyc();
        scl_in = 1'b1;
        repeat (10) cyc();
        sda_in = 1'b1;
        repeat (10) cyc();
        chk("stop_cnt", n_stop, 1);
        chk("stop_busy", int'(busy), 0);

        clr_counts();
        scl_in = 1'b0;
        sda_in = 1'b0;
        repeat (10) cyc();
        chk("simul_fall", n_fall, 1);
        chk("simul_no_start", n_start, 0);
        chk("simul_busy", int'(busy), 0);
        scl_in = 1'b1;
        sda_in = 1'b1;
        repeat (10) cyc();
        chk("simul_no_stop", n_stop, 0);

        // Low counter hits the limit 100 cycles after the fall; the flag registers one cycle later
        tmo_limit = 16'd100;
        clr_counts();
        scl_in = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            cyc();
            if (scl_fall) seen = 1;
        end
        chk("tmo_fall_seen", seen, 1);
        lat = 0;
        for (int i = 1; i <= 120; i++) begin
            cyc();
            if (stuck_scl && lat == 0) lat = i;
        end
        chk("tmo_stuck_latency", lat, 101);
        scl_in = 1'b1;
        repeat (10) cyc();
        chk("tmo_sticky", int'(stuck_scl), 1);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("tmo_clr", int'(stuck_scl), 0);
        cyc();
        chk("tmo_clr_hold", int'(stuck_scl), 0);
        tmo_limit = '0;
        scl_in = 1'b0;
        repeat (1000) cyc();
        chk("tmo_disabled", int'(stuck_scl), 0);
        scl_in = 1'b1;
        repeat (10) cyc();

        tmo_limit = 16'd20;
        sda_in = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (!sda_f && lat == 0) lat = i;
        end
        chk("sda_latency", lat, SYNC + FILT);
        repeat (30) cyc();
        chk("sda_stuck", int'(stuck_sda), 1);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("sda_clr_cycle", int'(stuck_sda), 0);
        cyc();
        chk("sda_reset_flag", int'(stuck_sda), 1);
        sda_in = 1'b1;
        repeat (10) cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        repeat (2) cyc();

        for (int k = 0; k < 16; k++) begin
            scl_in = tbl[k].scl;
            sda_in = tbl[k].sda;
            clr = tbl[k].clr;
            repeat (tbl[k].n) begin
                cyc();
                clr = 1'b0;
            end
            chk($sformatf("tbl_row%0d", k), int'({scl_f, sda_f, busy, stuck_scl, stuck_sda}),
                int'({tbl[k].e_scl, tbl[k].e_sda, tbl[k].e_busy, tbl[k].e_sk_scl, tbl[k].e_sk_sda}));
        end

        for (int k = 0; k < 400; k++) begin
            scl_in = 1'($urandom_range(0, 1));
            sda_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) tmo_limit = 16'($urandom_range(0, 30));
            clr = ($urandom_range(0, 15) == 0);
            hold = $urandom_range(1, 8);
            repeat (hold) begin
                cyc();
                clr = 1'b0;
            end
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0;
                model_reset();
                cyc();
                rst = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
